// File: rtl/mem_dados_if.sv
// Request/response bus between the control unit and the data memory.
// Handshake: a request (MemRead or MemWrite high) is taken on a rising edge where ready=1;
// it is answered by a one-cycle done pulse (err alongside for a rejected request).
interface mem_dados_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        done;
    logic        err;

    modport master (output MemRead, MemWrite, addr, wdata,
                    input  rdata, ready, done, err);
    modport slave  (input  MemRead, MemWrite, addr, wdata,
                    output rdata, ready, done, err);
endinterface

// File: rtl/mem_dados.sv
// Word-addressed data memory with a fixed number of wait states per access.
// An IDLE/BUSY/DONE controller sequences each access; bad requests complete with err.
module mem_dados #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic       clk,
    input  logic       reset,
    mem_dados_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          op_rd;
    logic          op_wr;
    logic          op_rej;
    logic [AW-1:0] op_idx;
    logic [31:0]   op_wdata;
    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          req_rej;
    logic          enter_done;
    logic          c_rd;
    logic          c_wr;
    logic          c_rej;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_wdata;
    logic          commit_wr;

    assign dbg_state = state;

    // With WAIT=0 DONE is entered on the acceptance edge itself, so the live
    // request is used there; otherwise the latched copy drives the access.
    always_comb begin
        req        = 1'b0;
        req_rej    = 1'b0;
        enter_done = 1'b0;
        c_rd       = op_rd;
        c_wr       = op_wr;
        c_rej      = op_rej;
        c_idx      = op_idx;
        c_wdata    = op_wdata;
        commit_wr  = 1'b0;

        req     = (state == IDLE) && (bus.MemRead || bus.MemWrite);
        req_rej = (bus.MemRead && bus.MemWrite) ||
                  (bus.addr[1:0] != 2'b00) ||
                  ({2'b00, bus.addr[31:2]} >= 32'(DEPTH));
        enter_done = (req && (WAIT == 0)) || ((state == BUSY) && (cnt == 4'd1));

        if (state == IDLE) begin
            c_rd    = bus.MemRead;
            c_wr    = bus.MemWrite;
            c_rej   = req_rej;
            c_idx   = bus.addr[AW+1:2];
            c_wdata = bus.wdata;
        end

        commit_wr = enter_done && c_wr && !c_rej && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= 32'h0;
            op_rd     <= 1'b0;
            op_wr     <= 1'b0;
            op_rej    <= 1'b0;
            op_idx    <= '0;
            op_wdata  <= 32'h0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            if (enter_done) begin
                state     <= DONE;
                cnt       <= 4'd0;
                bus.ready <= 1'b0;
                bus.done  <= 1'b1;
                bus.err   <= c_rej;
                if (c_rd && !c_rej) begin
                    bus.rdata <= mem[c_idx];
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            state     <= BUSY;
                            cnt       <= 4'(WAIT);
                            bus.ready <= 1'b0;
                        end
                    end
                    BUSY: cnt <= cnt - 4'd1;
                    DONE: begin
                        state     <= IDLE;
                        bus.ready <= 1'b1;
                    end
                    default: begin
                        state     <= IDLE;
                        bus.ready <= 1'b1;
                    end
                endcase
            end
            if (req) begin
                op_rd    <= bus.MemRead;
                op_wr    <= bus.MemWrite;
                op_rej   <= req_rej;
                op_idx   <= bus.addr[AW+1:2];
                op_wdata <= bus.wdata;
            end
        end
    end

    // The array is not reset; a write lands only on an unreset edge entering DONE.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[c_idx] <= c_wdata;
        end
    end
endmodule

// File: tb/tb_mem_dados.sv
// Bench for mem_dados: random traffic against an access-timeline model,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_dados;
  localparam int DEPTH = 64;
  localparam int WAIT  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_dados_if bus();
  mem_dados_if bus0();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state0;

  mem_dados #(.DEPTH(DEPTH), .WAIT(WAIT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );
  mem_dados #(.DEPTH(16), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .dbg_state(dbg_state0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An accepted access at edge a: done during the cycle after edge a+WAIT,
  // back to ready after edge a+WAIT+1, array/rdata effect at edge a+WAIT.
  int          n = 0;
  logic        m_flight = 1'b0;
  int          m_acc = 0;
  logic        m_rd = 1'b0;
  logic        m_wr = 1'b0;
  logic        m_rej = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    n++;
    if (reset) begin
      m_flight = 1'b0;
      m_rdata  = 32'h0;
    end else begin
      if (!m_flight && (bus.MemRead || bus.MemWrite)) begin
        m_flight = 1'b1;
        m_acc    = n;
        m_rd     = bus.MemRead;
        m_wr     = bus.MemWrite;
        m_addr   = bus.addr;
        m_wdata  = bus.wdata;
        m_rej    = (bus.MemRead && bus.MemWrite) || (bus.addr[1:0] != 2'b00) ||
                   (bus.addr[31:2] >= DEPTH);
      end
      if (m_flight && (n == m_acc + WAIT) && !m_rej) begin
        if (m_wr) m_mem[m_addr[31:2]] = m_wdata;
        else begin
          m_rdata = m_mem[m_addr[31:2]];
          exp_q.push_back(m_rdata);
        end
      end
      if (m_flight && (n == m_acc + WAIT + 1)) m_flight = 1'b0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic        exp_ready;
  logic        exp_done;
  logic        exp_err;
  logic [31:0] exp_rdata;

  always @(negedge clk) begin
    if (reset) begin
      exp_ready = 1'b1;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = 32'h0;
    end else begin
      exp_done  = m_flight && (n == m_acc + WAIT);
      exp_err   = exp_done && m_rej;
      exp_ready = !m_flight;
      exp_rdata = m_rdata;
    end
    check1("ready", bus.ready, exp_ready);
    check1("done", bus.done, exp_done);
    check1("err", bus.err, exp_err);
    check32("rdata", bus.rdata, exp_rdata);
    if (!reset && exp_done && m_rd && !m_rej) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_queue got empty expected entry at %0t", $time);
      end else begin
        check32("read_data", bus.rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.addr     = a;
    bus.wdata    = d;
  endtask

  task automatic idle_bus();
    drive(1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic junk();
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int guard;
    guard = 0;
    while (m_flight && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (m_flight) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got busy expected idle at %0t", $time);
    end
    drive(rd, wr, a, d);
    @(posedge clk); #1;
    repeat (WAIT + 1) begin
      junk();
      @(posedge clk); #1;
    end
    idle_bus();
  endtask

  task automatic lit_req(input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic exp_e);
    int lat;
    drive(rd, wr, a, d);
    @(posedge clk);
    lat = 1;
    #1 idle_bus();
    while (lat < 20) begin
      @(negedge clk);
      if (bus.done === 1'b1) break;
      @(posedge clk);
      lat++;
    end
    check32({name, "_latency"}, 32'(lat), 32'(WAIT + 1));
    check1({name, "_err"}, bus.err, exp_e);
    @(posedge clk); #1;
  endtask

  task automatic peek_rdata(input string name, input logic [31:0] exp);
    @(negedge clk);
    check32({name, "_dut"}, bus.rdata, exp);
    check32({name, "_model"}, m_rdata, exp);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          kind;
    int          gap;
    logic        rd;
    logic        wr;
    logic [31:0] a;

    idle_bus();
    bus0.MemRead  = 1'b0;
    bus0.MemWrite = 1'b0;
    bus0.addr     = 32'h0;
    bus0.wdata    = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_ready", bus.ready, 1'b1);
    check1("rst_done", bus.done, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    check32("rst_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom);

    lit_req("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    lit_req("rd10", 1'b1, 1'b0, 32'h10, $urandom, 1'b0);
    peek_rdata("rd10_data", 32'hDEADBEEF);
    lit_req("rd13", 1'b1, 1'b0, 32'h13, $urandom, 1'b1);
    peek_rdata("rd13_keep", 32'hDEADBEEF);
    lit_req("rd10b", 1'b1, 1'b0, 32'h10, $urandom, 1'b0);
    peek_rdata("rd10b_data", 32'hDEADBEEF);

    lit_req("wr20", 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0);
    lit_req("both20", 1'b1, 1'b1, 32'h20, 32'h22222222, 1'b1);
    lit_req("rd20", 1'b1, 1'b0, 32'h20, $urandom, 1'b0);
    peek_rdata("rd20_data", 32'h11111111);

    // Write aborted by reset one cycle after acceptance.
    lit_req("wr04", 1'b0, 1'b1, 32'h04, 32'h12345678, 1'b0);
    drive(1'b0, 1'b1, 32'h04, 32'hCAFEF00D);
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check1("abort_ready", bus.ready, 1'b1);
    check1("abort_done", bus.done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    lit_req("rd04", 1'b1, 1'b0, 32'h04, $urandom, 1'b0);
    peek_rdata("rd04_old", 32'h12345678);

    lit_req("rd_depth", 1'b1, 1'b0, 32'(4 * DEPTH), $urandom, 1'b1);
    lit_req("rd_last", 1'b1, 1'b0, 32'(4 * (DEPTH - 1)), $urandom, 1'b0);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, DEPTH - 1)) << 2;
      rd   = 1'b1;
      wr   = 1'b0;
      if (kind >= 4 && kind <= 6) begin rd = 1'b0; wr = 1'b1; end
      if (kind == 7) wr = 1'b1;
      if (kind == 8) a = a | 32'($urandom_range(1, 3));
      if (kind == 9) begin
        a  = 32'(DEPTH + $urandom_range(0, 1000)) << 2;
        rd = 1'($urandom_range(0, 1));
        wr = !rd;
      end
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      issue(rd, wr, a, $urandom);
    end

    // WAIT=0 instance with MemRead held high: accepted every second cycle.
    bus0.MemRead = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check1("w0_done", bus0.done, (k % 2) == 0);
      check1("w0_ready", bus0.ready, (k % 2) != 0);
      check1("w0_err", bus0.err, 1'b0);
    end
    #1 bus0.MemRead = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog got running expected finished at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_dados.md
MEM_DADOS -- requirements
Module: mem_dados

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words stored.
REQ-002 Parameter WAIT, default 2: wait-state cycles per access, legal range 0..15.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: reset is asynchronous and active-high.
REQ-005 Port MemRead  input  1: read request from the control unit.
REQ-006 Port MemWrite  input  1: write request from the control unit.
REQ-007 Port addr  input  32: byte address, word-aligned; word index = addr[31:2].
REQ-008 Port wdata  input  32: store data.
REQ-009 Port rdata  output  32: registered load data.
REQ-010 Port ready  output  1: high when the block can accept a request.
REQ-011 Port done  output  1: one-cycle pulse marking completion of an accepted request.
REQ-012 Port err  output  1: one-cycle pulse, coincident with done, marking a rejected request.

Function
REQ-013 FSM SHALL have states IDLE, BUSY, DONE; ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted on a rising edge where state=IDLE and (MemRead or MemWrite)=1; addr, wdata and op SHALL be latched at that edge.
REQ-015 Inputs SHALL be ignored while ready=0; changes after acceptance SHALL not affect the access in flight.
REQ-016 On acceptance, FSM SHALL go to BUSY with WAIT cycles remaining, or directly to DONE if WAIT=0.
REQ-017 BUSY SHALL last exactly WAIT cycles, down-counting a 4-bit counter; the transition to DONE occurs on the edge where the count reaches zero.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 The total latency from the acceptance edge to done high SHALL be WAIT+1 edges, and ready SHALL return 1 one cycle after done.
REQ-020 Write: the array word SHALL be updated on the edge entering DONE; rdata SHALL be unchanged.
REQ-021 Read: rdata SHALL load the addressed word on the edge entering DONE and hold it until the next successful read.
REQ-022 Rejection cases: MemRead and MemWrite both 1; addr[1:0]!=0; word index >= DEPTH.
REQ-023 A rejected request SHALL still follow the full BUSY/DONE timing, assert err=1 with done, leave the array unmodified and leave rdata unchanged.
REQ-024 A request presented in the DONE cycle SHALL be ignored; the next request is accepted only in IDLE.
REQ-025 Back-to-back requests SHALL be spaced at minimum WAIT+2 cycles between acceptances.

Reset
REQ-026 While reset=1: state=IDLE, counter=0, ready=1, done=0, err=0, rdata=32'h0.
REQ-027 Reset asserted during BUSY SHALL abort the access; a pending write SHALL not be committed.
REQ-028 Array contents SHALL not be cleared by reset; contents before the first write are undefined.

Verification
REQ-029 Write 0xDEADBEEF to addr 0x10, then read addr 0x10 (WAIT=2) -> done 3 edges after each acceptance; rdata=0xDEADBEEF; err=0.
REQ-030 Read with addr=0x13 -> done and err both pulse at latency WAIT+1; rdata keeps its prior value; the word at 0x10 is unchanged.
REQ-031 MemRead=MemWrite=1 at addr 0x20 holding 0x11111111 -> err pulse; a subsequent read returns 0x11111111.
REQ-032 Write 0xCAFEF00D to addr 0x04, assert reset one cycle after acceptance -> ready=1, done never pulses; a subsequent read of 0x04 returns the old value.
REQ-033 Read addr 4*DEPTH -> err pulse; read addr 4*(DEPTH-1) -> no err (wrap boundary).
REQ-034 WAIT=0, hold MemRead high continuously -> accepted every 2 cycles; done toggles 0/1; ready=0 during each DONE cycle.
